pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 15: max cycles in WAIT before fetch error.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 halt  input  1  when high, sequencer stops at next FETCH boundary.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  32  fetch address, equal to PC.
REQ-008 imem_ready  input  1  read data valid this cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 branchFlag  input  1  conditional-branch decode flag.
REQ-011 unconditionalBranchFlag  input  1  unconditional-branch decode flag.
REQ-012 zeroFlag  input  1  ALU zero result.
REQ-013 pcOffsetFilled  input  32  sign-extended branch offset, in words.
REQ-014 PC  output  32  current program counter.
REQ-015 instruction  output  32  latched instruction register.
REQ-016 decode_en, execute_en, writeback_en  output  1 each  one-cycle stage strobes.
REQ-017 fetch_error  output  1  sticky fetch-timeout flag.
REQ-018 halted  output  1  high while in HALT state.

Function
REQ-019 FSM states SHALL be FETCH, WAIT, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
REQ-020 FETCH: if halt=1 go HALT, else assert imem_req, imem_addr=PC, go WAIT next cycle.
REQ-021 WAIT: imem_req held high; on imem_ready=1 latch imem_rdata into instruction, go DECODE.
REQ-022 WAIT timeout counter SHALL clear on WAIT entry, increment per WAIT cycle without imem_ready; reaching FETCH_TIMEOUT with imem_ready=0 -> ERROR, fetch_error=1.
REQ-023 imem_ready in the same cycle the counter reaches FETCH_TIMEOUT SHALL win (DECODE, no error).
REQ-024 imem_ready outside WAIT SHALL be ignored.
REQ-025 DECODE: decode_en=1 for exactly one cycle, go EXECUTE.
REQ-026 EXECUTE: execute_en=1 for one cycle; sample flags; take = (zeroFlag & branchFlag) | unconditionalBranchFlag; go WRITEBACK.
REQ-027 WRITEBACK: writeback_en=1 for one cycle; at cycle end PC <= PC + (pcOffsetFilled << 2) if take, else PC + 4; go FETCH.
REQ-028 PC arithmetic SHALL be 32-bit modulo 2^32; shifted-out offset bits discarded; wrap-around silent.
REQ-029 take SHALL be registered in EXECUTE; flag changes during WRITEBACK have no effect.
REQ-030 HALT: halted=1, PC frozen; halt=0 returns to FETCH next cycle.
REQ-031 halt asserted outside FETCH SHALL NOT abort the current instruction.
REQ-032 ERROR: terminal, all strobes and imem_req low; exit only by reset.
REQ-033 Exactly one FSM state active per cycle; decode_en, execute_en, writeback_en mutually exclusive.
REQ-034 A fault-free instruction SHALL take 4 + N cycles, N = WAIT cycles (min 1).

Reset
REQ-035 reset_n=0 SHALL immediately force: state FETCH, PC=RESET_PC, instruction=0, counter=0, take=0, fetch_error=0, halted=0, all strobes and imem_req=0.
REQ-036 Reset mid-WAIT or mid-WRITEBACK SHALL discard the pending fetch/PC update; first fetch after release at RESET_PC.
REQ-037 First FETCH SHALL occur on the first posedge with reset_n=1.

Verification
REQ-038 Sequential: imem_ready 1 cycle after req, no branch flags, 3 instructions -> PC 0,4,8,12; each instruction 5 cycles.
REQ-039 Conditional: branchFlag=1, zeroFlag=1, offset=3 at PC=0x10 -> next PC 0x1C; zeroFlag=0 -> 0x14.
REQ-040 Backward/wrap: unconditionalBranchFlag=1, offset=32'hFFFF_FFFE at PC=0x4 -> PC 0xFFFF_FFFC.
REQ-041 Timeout: imem_ready held 0 -> fetch_error=1 after 15 WAIT cycles, ERROR persists; ready on 15th cycle -> DECODE, no error.
REQ-042 Halt: halt=1 during EXECUTE -> instruction completes, PC updated, halted=1 at next FETCH; halt=0 -> fetch resumes at updated PC.
REQ-043 Async reset mid-WAIT at PC=0x20 -> outputs reset without clock edge; next fetch address RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: fetch, wait for instruction memory,
// decode, execute, write back. Branch decisions are sampled in EXECUTE and
// applied to the PC at the end of WRITEBACK. A fetch that stalls too long
// parks the sequencer in a terminal ERROR state until reset.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        halt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        branchFlag,
   input  logic        unconditionalBranchFlag,
   input  logic        zeroFlag,
   input  logic [31:0] pcOffsetFilled,
   output logic [31:0] PC,
   output logic [31:0] instruction,
   output logic        decode_en,
   output logic        execute_en,
   output logic        writeback_en,
   output logic        fetch_error,
   output logic        halted
);

   localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(FETCH_TIMEOUT);

   typedef enum logic [2:0] {
      StFetch,
      StWait,
      StDecode,
      StExecute,
      StWriteback,
      StHalt,
      StError
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            take_q, take_d;
   logic            ferr_q, ferr_d;
   logic            imem_req_q, decode_en_q, execute_en_q, writeback_en_q, halted_q;
   logic [CntW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   // Next-state, datapath updates and branch decision.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      take_d  = take_q;
      ferr_d  = ferr_q;
      unique case (state_q)
         StFetch: begin
            if (halt) begin
               state_d = StHalt;
            end else begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            // A ready in the same cycle the timeout would fire still wins.
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = StDecode;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TimeoutVal) begin
                  state_d = StError;
                  ferr_d  = 1'b1;
               end
            end
         end
         StDecode: state_d = StExecute;
         StExecute: begin
            take_d  = (zeroFlag & branchFlag) | unconditionalBranchFlag;
            state_d = StWriteback;
         end
         StWriteback: begin
            // Offset is in words; bits shifted out the top are dropped.
            pc_d    = take_q ? pc_q + {pcOffsetFilled[29:0], 2'b00} : pc_q + 32'd4;
            state_d = StFetch;
         end
         StHalt: begin
            if (!halt) state_d = StFetch;
         end
         StError: state_d = StError;
         default: state_d = StError;
      endcase
   end

   // State and registered outputs; outputs reflect the state being entered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StFetch;
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         cnt_q          <= '0;
         take_q         <= 1'b0;
         ferr_q         <= 1'b0;
         imem_req_q     <= 1'b0;
         decode_en_q    <= 1'b0;
         execute_en_q   <= 1'b0;
         writeback_en_q <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         cnt_q          <= cnt_d;
         take_q         <= take_d;
         ferr_q         <= ferr_d;
         imem_req_q     <= (state_d == StWait);
         decode_en_q    <= (state_d == StDecode);
         execute_en_q   <= (state_d == StExecute);
         writeback_en_q <= (state_d == StWriteback);
         halted_q       <= (state_d == StHalt);
      end
   end

   assign imem_req     = imem_req_q;
   assign imem_addr    = pc_q;
   assign PC           = pc_q;
   assign instruction  = instr_q;
   assign decode_en    = decode_en_q;
   assign execute_en   = execute_en_q;
   assign writeback_en = writeback_en_q;
   assign fetch_error  = ferr_q;
   assign halted       = halted_q;

endmodule
